video_timing_rx: RTL

//  Sink-side counterpart of the frame generator. Takes a raw video stream (h_sync, v_sync, de,
//  24-bit pixel) and recovers per-pixel x/y coordinates and a frame-start pulse. Measures active
//  and total line/frame geometry, and declares lock when the stream matches WIDTH x HEIGHT.

---
 rtl/video_timing_rx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_rx.sv
// Sink-side video timing receiver: rebuilds x/y/frame from a raw sync/de stream,
// measures line and frame geometry, and tracks lock against WIDTH x HEIGHT.
module video_timing_rx #(
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 1024,
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int HTOT_W      = 12,
    parameter int VTOT_W      = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      h_sync,
    input  logic                      v_sync,
    input  logic                      de,
    input  logic [23:0]               data_in,
    output logic                      de_o,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic [23:0]               data_o,
    output logic                      frame,
    output logic [HTOT_W-1:0]         meas_hact,
    output logic [HTOT_W-1:0]         meas_htot,
    output logic [VTOT_W-1:0]         meas_vact,
    output logic [VTOT_W-1:0]         meas_vtot,
    output logic                      locked,
    output logic                      geom_err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
    localparam logic [XW-1:0]     X_LAST     = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST     = YW'(HEIGHT - 1);
    localparam logic [HTOT_W-1:0] H_MAX      = {HTOT_W{1'b1}};
    localparam logic [VTOT_W-1:0] V_MAX      = {VTOT_W{1'b1}};
    localparam logic [HTOT_W-1:0] H_ACT      = HTOT_W'(WIDTH);
    localparam logic [VTOT_W-1:0] V_ACT      = VTOT_W'(HEIGHT);
    localparam logic [CW-1:0]     LAST_MATCH = CW'(LOCK_FRAMES - 1);
    localparam logic [1:0]        SYNC_POL   = {(VS_POL != 0), (HS_POL != 0)};

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    // bit 0 = h_sync, bit 1 = v_sync, both normalised to active-high
    logic [1:0] sync_raw, sync_act;
    logic [1:0] sync_reg, sync_prev_reg;
    logic       de_reg, de_prev_reg;
    logic [23:0] data_reg;

    logic [HTOT_W-1:0] hact_cnt_reg, htot_cnt_reg, ref_htot_reg;
    logic [VTOT_W-1:0] vact_cnt_reg, vtot_cnt_reg, ref_vtot_reg;
    logic              first_line_reg, line_bad_reg, sat_reg;
    logic [CW-1:0]     match_cnt_reg;
    state_t            state_reg;

    logic              hs_edge, vs_edge, de_rise, de_fall;
    logic              line_bad_now, sat_now, geom_ok, same_ref;
    logic [HTOT_W-1:0] cur_htot;

    assign sync_raw = {v_sync, h_sync};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pol
            assign sync_act[gi] = SYNC_POL[gi] ? sync_raw[gi] : ~sync_raw[gi];
        end
    endgenerate

    function automatic logic [HTOT_W-1:0] h_inc(input logic [HTOT_W-1:0] v);
        return (v == H_MAX) ? v : v + HTOT_W'(1);
    endfunction

    function automatic logic [VTOT_W-1:0] v_inc(input logic [VTOT_W-1:0] v);
        return (v == V_MAX) ? v : v + VTOT_W'(1);
    endfunction

    assign hs_edge = sync_reg[0] & ~sync_prev_reg[0];
    assign vs_edge = sync_reg[1] & ~sync_prev_reg[1];
    assign de_rise = de_reg & ~de_prev_reg;
    assign de_fall = ~de_reg & de_prev_reg;

    assign line_bad_now = de_fall && (hact_cnt_reg != H_ACT);
    assign sat_now      = (htot_cnt_reg == H_MAX) || (hact_cnt_reg == H_MAX) ||
                          (vtot_cnt_reg == V_MAX) || (vact_cnt_reg == V_MAX);
    // Line length of the line just closed, including one closing on this very cycle
    assign cur_htot     = hs_edge ? htot_cnt_reg : meas_htot;
    assign geom_ok      = (vact_cnt_reg == V_ACT) && !line_bad_reg && !line_bad_now &&
                          !sat_reg && !sat_now;
    assign same_ref     = (cur_htot == ref_htot_reg) && (vtot_cnt_reg == ref_vtot_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg       <= '0;
            sync_prev_reg  <= '0;
            de_reg         <= 1'b0;
            de_prev_reg    <= 1'b0;
            data_reg       <= '0;
            de_o           <= 1'b0;
            data_o         <= '0;
            frame          <= 1'b0;
            x              <= '0;
            y              <= '0;
            first_line_reg <= 1'b1;
        end else begin
            sync_reg      <= sync_act;
            sync_prev_reg <= sync_reg;
            de_reg        <= de;
            de_prev_reg   <= de_reg;
            data_reg      <= data_in;
            de_o          <= de_reg;
            data_o        <= data_reg;
            frame         <= vs_edge;
            if (de_reg) begin
                if (de_rise)
                    x <= '0;
                else if (x != X_LAST)
                    x <= x + XW'(1);
            end
            // A frame edge coinciding with a de rise makes that line y=0
            if (vs_edge)
                first_line_reg <= 1'b1;
            if (de_rise) begin
                first_line_reg <= 1'b0;
                if (vs_edge || first_line_reg)
                    y <= '0;
                else if (y != Y_LAST)
                    y <= y + YW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hact_cnt_reg <= '0;
            htot_cnt_reg <= '0;
            vact_cnt_reg <= '0;
            vtot_cnt_reg <= '0;
            meas_hact    <= '0;
            meas_htot    <= '0;
            meas_vact    <= '0;
            meas_vtot    <= '0;
        end else begin
            if (hs_edge) begin
                meas_htot    <= htot_cnt_reg;
                htot_cnt_reg <= HTOT_W'(1);
            end else begin
                htot_cnt_reg <= h_inc(htot_cnt_reg);
                // A line that never closes reports the saturated length
                if (htot_cnt_reg == H_MAX)
                    meas_htot <= H_MAX;
            end
            if (de_rise)
                hact_cnt_reg <= HTOT_W'(1);
            else if (de_reg)
                hact_cnt_reg <= h_inc(hact_cnt_reg);
            if (de_fall)
                meas_hact <= hact_cnt_reg;
            if (vs_edge) begin
                meas_vact    <= vact_cnt_reg;
                meas_vtot    <= vtot_cnt_reg;
                vact_cnt_reg <= VTOT_W'(de_rise);
                vtot_cnt_reg <= VTOT_W'(hs_edge);
            end else begin
                if (de_rise)
                    vact_cnt_reg <= v_inc(vact_cnt_reg);
                if (hs_edge)
                    vtot_cnt_reg <= v_inc(vtot_cnt_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SEARCH;
            match_cnt_reg <= '0;
            ref_htot_reg  <= '0;
            ref_vtot_reg  <= '0;
            line_bad_reg  <= 1'b0;
            sat_reg       <= 1'b0;
            locked        <= 1'b0;
            geom_err      <= 1'b0;
        end else begin
            if (vs_edge) begin
                ref_htot_reg <= cur_htot;
                ref_vtot_reg <= vtot_cnt_reg;
                line_bad_reg <= 1'b0;
                sat_reg      <= 1'b0;
            end else begin
                line_bad_reg <= line_bad_reg | line_bad_now;
                sat_reg      <= sat_reg | sat_now;
            end
            case (state_reg)
                SEARCH: begin
                    if (vs_edge) begin
                        state_reg     <= MEASURE;
                        match_cnt_reg <= '0;
                    end
                end
                MEASURE: begin
                    // The first good frame of a run becomes the reference geometry
                    if (vs_edge) begin
                        if (geom_ok && (match_cnt_reg == '0 || same_ref)) begin
                            if (match_cnt_reg == LAST_MATCH) begin
                                state_reg     <= LOCKED;
                                match_cnt_reg <= '0;
                                locked        <= 1'b1;
                            end else begin
                                match_cnt_reg <= match_cnt_reg + CW'(1);
                            end
                        end else begin
                            match_cnt_reg <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad_now || htot_cnt_reg == H_MAX || vtot_cnt_reg == V_MAX ||
                        (vs_edge && !(geom_ok && same_ref))) begin
                        state_reg <= SEARCH;
                        locked    <= 1'b0;
                        geom_err  <= 1'b1;
                    end
                end
                default: state_reg <= SEARCH;
            endcase
        end
    end

endmodule
